// File: rtl/clock_div_pkg.sv
// Shared types and default constants for the divide-by-3 clock family.
package clock_div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } monitor_state_t;

  localparam int unsigned DIV_RATIO_DEF  = 3;
  localparam int unsigned LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/clock_ratio_monitor_if.sv
// Control and status bundle of the clock ratio monitor.
interface clock_ratio_monitor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             clk_div_in;
  logic             enable;
  logic             clear_fault;
  logic             edge_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             fault;

  modport master (
    output clk_div_in, enable, clear_fault,
    input  edge_pulse, period, period_valid, locked, fault
  );

  modport slave (
    input  clk_div_in, enable, clear_fault,
    output edge_pulse, period, period_valid, locked, fault
  );
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, followed by a rising-edge detector.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic d,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_ratio_monitor.sv
// Measures clk_div_in periods in clkin cycles, locks after a run of correct
// periods and raises a sticky fault on a wrong period or a lost clock.
module clock_ratio_monitor
  import clock_div_pkg::*;
#(
  parameter int unsigned DIV_RATIO   = DIV_RATIO_DEF,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int unsigned TIMEOUT     = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clkin,
  input logic                  reset,
  clock_ratio_monitor_if.slave mon
);
  localparam int unsigned      MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  monitor_state_t     state, state_nxt;
  logic [MATCH_W-1:0] match_cnt, match_nxt;
  logic               arm_clr;
  logic               rise;
  logic               timeout;
  logic               meas_ok;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   period_q;
  logic               armed;
  logic               edge_pulse_q;
  logic               period_valid_q;
  logic               locked_q;
  logic               fault_q;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clkin (clkin),
    .reset (reset),
    .d     (mon.clk_div_in),
    .rise  (rise)
  );

  assign timeout = (cnt == CNT_W'(TIMEOUT));
  assign meas_ok = (period_q == CNT_W'(DIV_RATIO));

  // State register; locked/fault follow the next state so they track it exactly.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      match_cnt <= '0;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      locked_q  <= (state_nxt == LOCKED);
      fault_q   <= (state_nxt == FAULT);
    end
  end

  // Decisions act on the registered measurement, one cycle after period_valid.
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    arm_clr   = 1'b0;
    if (!mon.enable) begin
      state_nxt = IDLE;
      match_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ACQUIRE;
          match_nxt = '0;
        end
        ACQUIRE: begin
          if (timeout) begin
            match_nxt = '0;
            arm_clr   = 1'b1;
          end else if (period_valid_q) begin
            if (!meas_ok) begin
              match_nxt = '0;
            end else if (match_cnt == MATCH_W'(LOCK_COUNT - 1)) begin
              match_nxt = '0;
              state_nxt = LOCKED;
            end else begin
              match_nxt = match_cnt + MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          if (timeout || (period_valid_q && !meas_ok)) state_nxt = FAULT;
        end
        FAULT: begin
          if (mon.clear_fault) begin
            state_nxt = ACQUIRE;
            match_nxt = '0;
            arm_clr   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Period counter and measurement; the first edge after (re)arming only starts timing.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      armed          <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      edge_pulse_q   <= 1'b0;
    end else begin
      edge_pulse_q   <= rise;
      period_valid_q <= 1'b0;
      if (state == IDLE) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else begin
        if (rise)                cnt <= '0;
        else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

        if (arm_clr) begin
          armed <= 1'b0;
        end else if (rise) begin
          armed <= 1'b1;
          if (armed) begin
            period_q       <= (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            period_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign mon.edge_pulse   = edge_pulse_q;
  assign mon.period       = period_q;
  assign mon.period_valid = period_valid_q;
  assign mon.locked       = locked_q;
  assign mon.fault        = fault_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Directed plus randomized bench for clock_ratio_monitor, checked every cycle
// against an edge-time reference model.
module tb_clock_ratio_monitor;
  localparam int DIV   = 3;
  localparam int LOCKN = 4;
  localparam int TMO   = 12;
  localparam int SYNC  = 2;
  localparam int SAT   = 255;

  localparam int M_IDLE  = 0;
  localparam int M_ACQ   = 1;
  localparam int M_LOCK  = 2;
  localparam int M_FAULT = 3;

  logic clkin;
  logic reset;

  clock_ratio_monitor_if #(.CNT_W(8)) mon ();

  clock_ratio_monitor #(
    .DIV_RATIO   (DIV),
    .CNT_W       (8),
    .LOCK_COUNT  (LOCKN),
    .TIMEOUT     (TMO),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clkin (clkin),
    .reset (reset),
    .mon   (mon)
  );

  initial clkin = 1'b0;
  always #10 clkin = ~clkin;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: times of sampled edges and the lock/fault rules.
  int n;
  bit hist[$];
  int m_mode;
  int m_streak;
  bit m_armed;
  int m_ref;
  int m_last_ep;
  bit e_ep, e_pv, e_locked, e_fault;
  int e_period;

  function automatic bit smp(input int k);
    return (k >= 1 && k <= hist.size()) ? hist[k-1] : 1'b0;
  endfunction

  task automatic model_reset();
    n = 0;
    hist.delete();
    m_mode = M_IDLE;
    m_streak = 0;
    m_armed = 0;
    m_ref = 0;
    m_last_ep = 0;
    e_ep = 0; e_pv = 0; e_locked = 0; e_fault = 0;
    e_period = 0;
  endtask

  task automatic model_step();
    bit ep, tmo, disarm;
    int nm, gap;
    n++;
    hist.push_back(mon.clk_div_in);
    ep     = smp(n - SYNC) && !smp(n - SYNC - 1);
    tmo    = (m_mode != M_IDLE) && ((n - 1 - m_ref) == TMO);
    disarm = 0;
    nm     = m_mode;
    if (!mon.enable) begin
      nm = M_IDLE;
      m_streak = 0;
    end else if (m_mode == M_IDLE) begin
      nm = M_ACQ;
      m_streak = 0;
    end else if (m_mode == M_ACQ) begin
      if (tmo) begin
        m_streak = 0;
        disarm = 1;
      end else if (e_pv) begin
        if (e_period == DIV) begin
          m_streak++;
          if (m_streak == LOCKN) begin
            nm = M_LOCK;
            m_streak = 0;
          end
        end else begin
          m_streak = 0;
        end
      end
    end else if (m_mode == M_LOCK) begin
      if (tmo || (e_pv && e_period != DIV)) nm = M_FAULT;
    end else begin
      if (mon.clear_fault) begin
        nm = M_ACQ;
        m_streak = 0;
        disarm = 1;
      end
    end
    e_pv = 0;
    if (m_mode == M_IDLE) begin
      m_armed = 0;
      m_ref = n;
    end else begin
      if (ep) m_ref = n;
      if (disarm) begin
        m_armed = 0;
      end else if (ep) begin
        if (m_armed) begin
          gap = n - m_last_ep;
          e_pv = 1;
          e_period = (gap > SAT) ? SAT : gap;
        end
        m_armed = 1;
      end
    end
    if (ep) m_last_ep = n;
    e_ep     = ep;
    m_mode   = nm;
    e_locked = (nm == M_LOCK);
    e_fault  = (nm == M_FAULT);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("edge_pulse",   32'(mon.edge_pulse),   32'(e_ep));
    check("period_valid", 32'(mon.period_valid), 32'(e_pv));
    check("period",       32'(mon.period),       32'(e_period));
    check("locked",       32'(mon.locked),       32'(e_locked));
    check("fault",        32'(mon.fault),        32'(e_fault));
  endtask

  task automatic tick();
    @(posedge clkin);
    if (!reset) model_reset();
    else        model_step();
    @(negedge clkin);
    check_outputs();
  endtask

  // One clk_div_in period of p cycles with a random high phase; optionally
  // pulses clear_fault in the same cycle as any mismatching period_valid.
  task automatic run_period(input int p, input bit clr_on_bad);
    int hi;
    hi = int'($urandom_range(1, p - 1));
    for (int i = 0; i < p; i++) begin
      mon.clk_div_in = (i < hi);
      tick();
      mon.clear_fault = 1'b0;
      if (clr_on_bad && e_pv && e_period != DIV) mon.clear_fault = 1'b1;
    end
  endtask

  task automatic run_periods(input int p, input int count);
    for (int i = 0; i < count; i++) run_period(p, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sel;
    model_reset();
    reset = 1'b1;
    mon.enable = 1'b1;
    mon.clk_div_in = 1'b0;
    mon.clear_fault = 1'b0;
    #5 reset = 1'b0;

    // Reset held with enable=1 and activity on clk_div_in.
    mon.clk_div_in = 1'b1;
    tick();
    mon.clk_div_in = 1'b0;
    tick();
    mon.clk_div_in = 1'b1;
    tick();
    mon.clk_div_in = 1'b0;
    reset = 1'b1;

    // Clean acquisition with divide-by-3.
    run_periods(3, 8);
    check("clean_locked", 32'(mon.locked), 32'd1);
    check("clean_fault",  32'(mon.fault),  32'd0);
    check("clean_period", 32'(mon.period), 32'd3);

    // Lost clock after lock.
    mon.clk_div_in = 1'b0;
    repeat (16) tick();
    check("lost_fault",  32'(mon.fault),  32'd1);
    check("lost_locked", 32'(mon.locked), 32'd0);

    mon.clear_fault = 1'b1;
    tick();
    mon.clear_fault = 1'b0;
    check("lost_clear", 32'(mon.fault), 32'd0);
    run_periods(3, 6);
    check("relock_after_lost", 32'(mon.locked), 32'd1);

    // Wrong period while locked.
    run_period(4, 1'b0);
    run_period(3, 1'b0);
    check("wrong_period", 32'(mon.period), 32'd4);
    tick();
    check("wrong_fault", 32'(mon.fault), 32'd1);
    mon.clear_fault = 1'b1;
    tick();
    mon.clear_fault = 1'b0;
    check("wrong_clear", 32'(mon.fault), 32'd0);
    run_periods(3, 6);
    check("relock_after_wrong", 32'(mon.locked), 32'd1);

    // enable=0 while locked, then acquisition restart on a short period.
    mon.enable = 1'b0;
    tick();
    check("disable_locked", 32'(mon.locked), 32'd0);
    mon.enable = 1'b1;
    tick();
    run_periods(3, 3);
    run_period(2, 1'b0);
    run_periods(3, 4);
    check("restart_no_lock", 32'(mon.locked), 32'd0);
    run_periods(3, 2);
    check("restart_lock", 32'(mon.locked), 32'd1);

    // clear_fault coinciding with a fresh mismatch.
    run_period(5, 1'b0);
    run_period(4, 1'b0);
    run_period(3, 1'b1);
    check("coincide_pre_fault", 32'(mon.fault), 32'd1);
    tick();
    mon.clear_fault = 1'b0;
    check("coincide_fault",  32'(mon.fault),  32'd0);
    check("coincide_locked", 32'(mon.locked), 32'd0);

    // Asynchronous reset while locked.
    run_periods(3, 6);
    check("pre_reset_locked", 32'(mon.locked), 32'd1);
    reset = 1'b0;
    #1;
    model_reset();
    check("async_edge_pulse",   32'(mon.edge_pulse),   32'd0);
    check("async_period_valid", 32'(mon.period_valid), 32'd0);
    check("async_period",       32'(mon.period),       32'd0);
    check("async_locked",       32'(mon.locked),       32'd0);
    check("async_fault",        32'(mon.fault),        32'd0);
    mon.clk_div_in = 1'b1;
    tick();
    mon.clk_div_in = 1'b0;
    tick();
    reset = 1'b1;

    // Randomized traffic against the model.
    for (int r = 0; r < 90; r++) begin
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        mon.enable = 1'b0;
        tick();
        mon.enable = 1'b1;
      end else if (sel == 1) begin
        mon.clear_fault = 1'b1;
        tick();
        mon.clear_fault = 1'b0;
      end else if (sel == 2) begin
        mon.clk_div_in = 1'b0;
        repeat ($urandom_range(5, 16)) tick();
      end else if (sel < 14) begin
        run_period(3, 1'b0);
      end else begin
        run_period(int'($urandom_range(2, 6)), sel[0]);
      end
    end
    mon.clear_fault = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
